// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 16-bit core.
// Owns the PC, handles redirect/stall, and drains the pipeline before halting on HLT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] NOP_INSTR    = 16'h0000,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [15:0] imem_data,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted
);

    localparam logic [3:0] HltOpcode = 4'hF;
    localparam logic [3:0] CntInit   = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StCount,
        StHalted
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus2_q, pc_plus2_d;
    logic        valid_q, valid_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] pc_next_seq;

    assign pc_next_seq = pc_q + 16'd2;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus2_d = pc_plus2_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            StRun: begin
                if (redirect) begin
                    pc_d    = redirect_pc & 16'hFFFE;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d    = imem_data;
                    pc_plus2_d = pc_next_seq;
                    valid_d    = 1'b1;
                    // HLT is latched but the PC stays on it so nothing past it is fetched.
                    if (imem_data[15:12] != HltOpcode) begin
                        pc_d = pc_next_seq;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (redirect) begin
                    pc_d    = redirect_pc & 16'hFFFE;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = StRun;
                end else if (!stall) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    cnt_d   = CntInit;
                    state_d = StCount;
                end
            end
            StCount: begin
                if (cnt_q == 4'd0) begin
                    state_d = StHalted;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_addr      = pc_q;
    assign imem_rd_en     = (state_q == StRun) && !rst;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus2 = pc_plus2_q;
    assign if_id_valid    = valid_q;
    assign halted         = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vectors with expected post-edge outputs, checked
// through a scoreboard queue; imem returns {4'h1, addr[11:0]} except HLT at hlt_addr.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] hlt_addr;

    int n_cmp;
    int n_err;

    fetch_stage #(
        .RESET_PC    (16'h0000),
        .NOP_INSTR   (16'h0000),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rd_en    (imem_rd_en),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus2(if_id_pc_plus2),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = (imem_addr == hlt_addr) ? 16'hF000 : {4'h1, imem_addr[11:0]};

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic [15:0] addr;
        logic        rd_en;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        chk_pc2;
        logic        valid;
        logic        halted;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[10];

    function automatic vec_t mk(input logic r, input logic s, input logic rd,
                                input logic [15:0] rpc, input logic [15:0] addr,
                                input logic en, input logic [15:0] instr,
                                input logic [15:0] pc2, input logic chk_pc2,
                                input logic valid, input logic hlt);
        vec_t v;
        v.rst = r; v.stall = s; v.redirect = rd; v.rpc = rpc;
        v.addr = addr; v.rd_en = en; v.instr = instr; v.pc2 = pc2;
        v.chk_pc2 = chk_pc2; v.valid = valid; v.halted = hlt;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        vec_t e;
        rst         = v.rst;
        stall       = v.stall;
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".imem_addr"}, imem_addr, e.addr);
        check({tag, ".imem_rd_en"}, {15'd0, imem_rd_en}, {15'd0, e.rd_en});
        check({tag, ".if_id_valid"}, {15'd0, if_id_valid}, {15'd0, e.valid});
        check({tag, ".if_id_instr"}, if_id_instr, e.instr);
        check({tag, ".halted"}, {15'd0, halted}, {15'd0, e.halted});
        if (e.chk_pc2) check({tag, ".if_id_pc_plus2"}, if_id_pc_plus2, e.pc2);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        hlt_addr    = 16'hFFFF;

        //              rst  stl  rd   rpc       addr      en   instr     pc2       chk  v    h
        tbl[0] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 16'h1000, 16'h0002, 1'b1, 1'b1, 1'b0);
        tbl[2] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 16'h1002, 16'h0004, 1'b1, 1'b1, 1'b0);
        tbl[3] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0004, 1'b1, 16'h1002, 16'h0004, 1'b1, 1'b1, 1'b0);
        tbl[4] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0004, 1'b1, 16'h1002, 16'h0004, 1'b1, 1'b1, 1'b0);
        tbl[5] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 1'b1, 16'h1004, 16'h0006, 1'b1, 1'b1, 1'b0);
        tbl[6] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0008, 1'b1, 16'h1006, 16'h0008, 1'b1, 1'b1, 1'b0);
        tbl[7] = mk(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0010, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        // Redirect wins over a simultaneous stall; bit 0 of the target is dropped.
        tbl[8] = mk(1'b0, 1'b1, 1'b1, 16'h0041, 16'h0040, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tbl[9] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0042, 1'b1, 16'h1040, 16'h0042, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Wrong-path HLT: fetched, then squashed by a redirect while draining.
        hlt_addr = 16'h0020;
        step("wp_redir", mk(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0020, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        step("wp_hlt",   mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0020, 1'b0, 16'hF000, 16'h0022, 1'b1, 1'b1, 1'b0));
        step("wp_flush", mk(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0100, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        step("wp_resume",mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0102, 1'b1, 16'h1100, 16'h0102, 1'b1, 1'b1, 1'b0));

        // Normal halt with DRAIN_CYCLES=3; redirects during COUNT/HALTED are ignored.
        hlt_addr = 16'h0030;
        step("h_redir",  mk(1'b0, 1'b0, 1'b1, 16'h0030, 16'h0030, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        step("h_fetch",  mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0030, 1'b0, 16'hF000, 16'h0032, 1'b1, 1'b1, 1'b0));
        step("h_leave",  mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0030, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        step("h_e1",     mk(1'b0, 1'b0, 1'b1, 16'h0300, 16'h0030, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        step("h_e2",     mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0030, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        step("h_e3",     mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0030, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1));
        step("h_sticky", mk(1'b0, 1'b0, 1'b1, 16'h0200, 16'h0030, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1));
        step("h_hold",   mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0030, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1));

        // Reset out of HALTED, then reset again in the middle of COUNT.
        step("r_rst",    mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0));
        step("r_redir",  mk(1'b0, 1'b0, 1'b1, 16'h0030, 16'h0030, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        step("r_fetch",  mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0030, 1'b0, 16'hF000, 16'h0032, 1'b1, 1'b1, 1'b0));
        step("r_leave",  mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0030, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        step("r_midcnt", mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0));
        step("r_run",    mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 16'h1000, 16'h0002, 1'b1, 1'b1, 1'b0));
        step("r_nohalt", mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 16'h1002, 16'h0004, 1'b1, 1'b1, 1'b0));

        // PC wrap at the top of the address space.
        step("w_redir",  mk(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        step("w_wrap",   mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1FFE, 16'h0000, 1'b1, 1'b1, 1'b0));
        step("w_next",   mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 16'h1000, 16'h0002, 1'b1, 1'b1, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
